// File: rtl/hpdcache_sram_arbiter.sv
// -----------------------------------------------------------------------------
// hpdcache_sram_arbiter
//
// Arbitrates two requesters onto one single-port byte-enable SRAM macro.
// At most one access is granted per cycle. Read data comes back one cycle
// after the grant and is queued in a 2-entry response FIFO with
// valid/ready backpressure. After reset the whole array can be zero-filled,
// because the macro has no hardware initialisation of its own.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid_i     per-requester request valid (index 0 = higher base priority)
//   req_ready_o     per-requester grant, one-hot or zero, combinational
//   req_we_i        per-requester write (1) / read (0)
//   req_addr_i      per-requester word address
//   req_wdata_i     per-requester write data
//   req_wbe_i       per-requester write byte enables
//   rsp_valid_o     read response valid
//   rsp_ready_i     read response consumed
//   rsp_id_o        requester index that issued the read
//   rsp_rdata_o     read data
//   init_done_o     array initialised and usable
//   sram_*          macro chip select, write enable, address, data, byte enables
//   sram_rdata_i    macro read data, valid the cycle after a read select
// -----------------------------------------------------------------------------
module hpdcache_sram_arbiter #(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter int unsigned MAX_STARVE    = 4,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [1:0]                           req_valid_i,
  output logic [1:0]                           req_ready_o,
  input  logic [1:0]                           req_we_i,
  input  logic [1:0][ADDR_SIZE-1:0]            req_addr_i,
  input  logic [1:0][DATA_SIZE-1:0]            req_wdata_i,
  input  logic [1:0][DATA_SIZE/8-1:0]          req_wbe_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic                                 rsp_id_o,
  output logic [DATA_SIZE-1:0]                 rsp_rdata_o,
  output logic                                 init_done_o,
  output logic                                 sram_cs_o,
  output logic                                 sram_we_o,
  output logic [ADDR_SIZE-1:0]                 sram_addr_o,
  output logic [DATA_SIZE-1:0]                 sram_wdata_o,
  output logic [DATA_SIZE/8-1:0]               sram_wbe_o,
  input  logic [DATA_SIZE-1:0]                 sram_rdata_i
);

  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                 state;
  // init_go holds the init sequencer off until the first edge after reset
  // release, so the macro is never selected while rst_n is low.
  logic                   init_go;
  logic [ADDR_SIZE-1:0]   init_cnt;
  logic                   init_done_q;

  logic                   inflight;
  logic                   inflight_id;
  logic [STARVE_W-1:0]    starve_cnt;

  logic [DATA_SIZE-1:0]   fifo_data [2];
  logic                   fifo_id   [2];
  logic                   fifo_rd_ptr;
  logic                   fifo_wr_ptr;
  logic [1:0]             fifo_cnt;

  logic                   pop;
  logic [2:0]             pending;
  logic                   credit;
  logic [1:0]             eligible;
  logic                   starved;
  logic [1:0]             grant;
  logic                   win_id;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign rsp_valid_o = (fifo_cnt != 2'd0);
  assign rsp_id_o    = fifo_id[fifo_rd_ptr];
  assign rsp_rdata_o = fifo_data[fifo_rd_ptr];
  assign pop         = rsp_valid_o && rsp_ready_i;

  // A read may only be issued if its data is guaranteed a FIFO slot: count the
  // read still in the SRAM pipe plus queued entries, minus the one leaving now.
  // pop implies fifo_cnt >= 1, so the subtraction cannot wrap.
  assign pending  = {2'b00, inflight} + {1'b0, fifo_cnt} - {2'b00, pop};
  assign credit   = (pending < 3'd2);
  assign eligible = req_valid_i & (req_we_i | {2{credit}});
  assign starved  = (starve_cnt == STARVE_W'(MAX_STARVE));

  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path leaves it holding its old value and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (state == ST_RUN) begin
      if (starved && eligible[1]) begin
        grant = 2'b10;
      end else if (eligible[0]) begin
        grant = 2'b01;
      end else if (eligible[1]) begin
        grant = 2'b10;
      end
    end
  end

  assign win_id      = grant[1];
  assign req_ready_o = grant;
  assign init_done_o = init_done_q;

  // ---------------------------------------------------------------------------
  // SRAM port mux: init sequencer owns the macro in INIT, the winner in RUN
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_addr_i[win_id];
    sram_wdata_o = req_wdata_i[win_id];
    sram_wbe_o   = req_wbe_i[win_id];
    if (state == ST_INIT) begin
      sram_cs_o    = init_go;
      sram_we_o    = init_go;
      sram_addr_o  = init_cnt;
      sram_wdata_o = '0;
      sram_wbe_o   = '1;
    end else if (grant != 2'b00) begin
      sram_cs_o = 1'b1;
      sram_we_o = req_we_i[win_id];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_go     <= 1'b0;
      init_cnt    <= '0;
      init_done_q <= !INIT_ON_RESET;
      inflight    <= 1'b0;
      inflight_id <= 1'b0;
      starve_cnt  <= '0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      init_go <= 1'b1;

      case (state)
        ST_INIT: begin
          if (init_go) begin
            if (init_cnt == ADDR_SIZE'(DEPTH - 1)) begin
              state       <= ST_RUN;
              init_done_q <= 1'b1;
              init_cnt    <= '0;
            end else begin
              init_cnt <= init_cnt + ADDR_SIZE'(1);
            end
          end
        end
        default: begin
          if (!req_valid_i[1] || grant[1]) begin
            starve_cnt <= '0;
          end else if (!starved) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
        end
      endcase

      inflight    <= (grant != 2'b00) && !req_we_i[win_id];
      inflight_id <= win_id;

      // The read data for last cycle's grant is on sram_rdata_i now.
      if (inflight) begin
        fifo_wr_ptr <= ~fifo_wr_ptr;
      end
      if (pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // NOTE: FIFO storage has no reset; the valid count gates every read of it,
  // so clearing the pointers and count is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (inflight) begin
      fifo_data[fifo_wr_ptr] <= sram_rdata_i;
      fifo_id[fifo_wr_ptr]   <= inflight_id;
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_sram_arbiter
//
// Directed bench for hpdcache_sram_arbiter with a behavioural byte-enable
// SRAM model. A cycle table covers write/read, starvation, backpressure and
// simultaneous push/pop; hand-written sequences cover init and resets.
// -----------------------------------------------------------------------------
module tb_hpdcache_sram_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 64;

  localparam logic [63:0] D_W = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] R_5 = 64'h00000000_CAFEF00D;
  localparam logic [63:0] D_1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D_2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D_3 = 64'h9999_AAAA_BBBB_CCCC;

  logic                   clk;
  logic                   rst_n;
  logic [1:0]             valid;
  logic [1:0]             ready;
  logic [1:0]             we;
  logic [1:0][AW-1:0]     addr;
  logic [1:0][DW-1:0]     wdata;
  logic [1:0][BW-1:0]     wbe;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [DW-1:0]          rsp_rdata;
  logic                   init_done;
  logic                   sram_cs;
  logic                   sram_we;
  logic [AW-1:0]          sram_addr;
  logic [DW-1:0]          sram_wdata;
  logic [BW-1:0]          sram_wbe;
  logic [DW-1:0]          sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  hpdcache_sram_arbiter #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH), .MAX_STARVE(4), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(valid), .req_ready_o(ready), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_wbe_i(wbe),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_rdata_o(rsp_rdata), .init_done_o(init_done),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wbe_o(sram_wbe), .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // SRAM model: seeded with non-zero garbage, one-cycle read latency
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic          mem_seeded = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'hA5A5_5A5A_0000_0000 | 64'(i);
      mem_seeded <= 1'b1;
    end else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wbe);
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},     64'(ready),     64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_cs"},        64'(sram_cs),   64'd0);
    check({tag, "_we"},        64'(sram_we),   64'd0);
    check({tag, "_init_done"}, 64'(init_done), 64'd0);
  endtask

  // Runs from just after a reset release (driven at a negedge). Cycle k is the
  // interval after the k-th rising edge. abort_addr >= 0 asserts reset in the
  // middle of the cycle that writes that address.
  task automatic do_init(input int abort_addr, input string tag);
    int errs;
    errs = 0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(posedge clk); #1;
      if (k <= DEPTH) begin
        valid = 2'b01; we = 2'b01; addr[0] = 6'd7; wdata[0] = D_1; wbe[0] = 8'hFF;
      end else begin
        valid = 2'b00;
      end
      #3;
      if (k <= DEPTH) begin
        if (!(sram_cs === 1'b1 && sram_we === 1'b1 && sram_addr === AW'(k - 1) &&
              sram_wdata === '0 && sram_wbe === '1 && ready === 2'b00 &&
              init_done === 1'b0)) errs++;
        if (k - 1 == abort_addr) begin
          check({tag, "_pattern_before_abort"}, 64'(errs), 64'd0);
          rst_n = 1'b0;
          #1;
          check_reset_outputs({tag, "_abort"});
          valid = 2'b00;
          return;
        end
      end else begin
        check({tag, "_done_rise"}, 64'(init_done), 64'd1);
        check({tag, "_cs_after"},  64'(sram_cs),   64'd0);
      end
    end
    check({tag, "_pattern"}, 64'(errs), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Cycle table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [BW-1:0] be0, be1;
    logic          rr;
    logic [1:0]    exp_ready;
    logic          exp_rv;
    logic          exp_id;
    logic [DW-1:0] exp_data;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [BW-1:0] be0, input logic [BW-1:0] be1,
                              input logic rr, input logic [1:0] er,
                              input logic erv, input logic eid, input logic [DW-1:0] ed);
    vec_t t;
    t.valid = v; t.we = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.be0 = be0; t.be1 = be1; t.rr = rr; t.exp_ready = er;
    t.exp_rv = erv; t.exp_id = eid; t.exp_data = ed;
    return t;
  endfunction

  function automatic vec_t idle(input logic rr, input logic erv, input logic [DW-1:0] ed);
    return mk(2'b00, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0, 8'h00, 8'h00, rr, 2'b00, erv, 1'b0, ed);
  endfunction

  function automatic vec_t rd0(input logic [AW-1:0] a, input logic rr, input logic [1:0] er,
                               input logic erv, input logic [DW-1:0] ed);
    return mk(2'b01, 2'b00, a, 6'd0, 64'd0, 64'd0, 8'h00, 8'h00, rr, er, erv, 1'b0, ed);
  endfunction

  initial begin
    // write then read back through requester 1
    vecs[0]  = mk(2'b01, 2'b01, 6'd5, 6'd0, D_W, 64'd0, 8'h0F, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 64'd0);
    vecs[1]  = mk(2'b10, 2'b00, 6'd0, 6'd5, 64'd0, 64'd0, 8'h00, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 64'd0);
    vecs[2]  = idle(1'b1, 1'b0, 64'd0);
    vecs[3]  = mk(2'b00, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 1'b1, R_5);
    vecs[4]  = idle(1'b1, 1'b0, 64'd0);
    // starvation: 4 grants to 0, 1 grant to 1, repeated
    for (int i = 5; i <= 14; i++)
      vecs[i] = mk(2'b11, 2'b11, 6'd1, 6'd2, D_1, D_2, 8'hFF, 8'hFF, 1'b1,
                   (i == 9 || i == 14) ? 2'b10 : 2'b01, 1'b0, 1'b0, 64'd0);
    vecs[15] = idle(1'b1, 1'b0, 64'd0);
    // backpressure: two reads, then only requester 1 writes get through
    vecs[16] = rd0(6'd1, 1'b0, 2'b01, 1'b0, 64'd0);
    vecs[17] = rd0(6'd2, 1'b0, 2'b01, 1'b0, 64'd0);
    vecs[18] = mk(2'b11, 2'b10, 6'd2, 6'd3, 64'd0, D_3, 8'h00, 8'hFF, 1'b0, 2'b10, 1'b1, 1'b0, D_1);
    vecs[19] = mk(2'b11, 2'b10, 6'd2, 6'd3, 64'd0, D_3, 8'h00, 8'hFF, 1'b0, 2'b10, 1'b1, 1'b0, D_1);
    vecs[20] = rd0(6'd3, 1'b0, 2'b00, 1'b1, D_1);
    vecs[21] = rd0(6'd3, 1'b1, 2'b01, 1'b1, D_1);
    vecs[22] = rd0(6'd1, 1'b1, 2'b01, 1'b1, D_2);
    vecs[23] = idle(1'b1, 1'b1, D_3);
    vecs[24] = idle(1'b1, 1'b1, D_1);
    vecs[25] = idle(1'b1, 1'b0, 64'd0);
    // fill the FIFO, then stream reads with push and pop every cycle
    vecs[26] = rd0(6'd1, 1'b0, 2'b01, 1'b0, 64'd0);
    vecs[27] = rd0(6'd2, 1'b0, 2'b01, 1'b0, 64'd0);
    vecs[28] = rd0(6'd3, 1'b0, 2'b00, 1'b1, D_1);
    vecs[29] = rd0(6'd3, 1'b0, 2'b00, 1'b1, D_1);
    vecs[30] = rd0(6'd3, 1'b1, 2'b01, 1'b1, D_1);
    vecs[31] = rd0(6'd1, 1'b1, 2'b01, 1'b1, D_2);
    vecs[32] = rd0(6'd2, 1'b1, 2'b01, 1'b1, D_3);
    vecs[33] = rd0(6'd3, 1'b1, 2'b01, 1'b1, D_1);
    vecs[34] = idle(1'b1, 1'b1, D_2);
    vecs[35] = idle(1'b1, 1'b1, D_3);
    vecs[36] = idle(1'b1, 1'b0, 64'd0);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int nz;
    rst_n = 1'b0; valid = 2'b00; we = 2'b00; rsp_ready = 1'b0;
    addr = '0; wdata = '0; wbe = '0;

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");

    @(negedge clk) rst_n = 1'b1;
    do_init(-1, "init");

    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
    check("init_mem_zero", 64'(nz), 64'd0);

    for (int i = 0; i < NV; i++) begin
      logic exp_we;
      @(posedge clk); #1;
      valid = vecs[i].valid; we = vecs[i].we;
      addr[0] = vecs[i].a0; addr[1] = vecs[i].a1;
      wdata[0] = vecs[i].d0; wdata[1] = vecs[i].d1;
      wbe[0] = vecs[i].be0; wbe[1] = vecs[i].be1;
      rsp_ready = vecs[i].rr;
      #3;
      exp_we = vecs[i].exp_ready[1] ? vecs[i].we[1] :
               vecs[i].exp_ready[0] ? vecs[i].we[0] : 1'b0;
      check($sformatf("v%0d_ready", i),     64'(ready),     64'(vecs[i].exp_ready));
      check($sformatf("v%0d_cs", i),        64'(sram_cs),   64'(|vecs[i].exp_ready));
      check($sformatf("v%0d_we", i),        64'(sram_we),   64'(exp_we));
      check($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_ready != 2'b00)
        check($sformatf("v%0d_addr", i), 64'(sram_addr),
              64'(vecs[i].exp_ready[1] ? vecs[i].a1 : vecs[i].a0));
      if (vecs[i].exp_rv) begin
        check($sformatf("v%0d_rsp_id", i),    64'(rsp_id), 64'(vecs[i].exp_id));
        check($sformatf("v%0d_rsp_rdata", i), rsp_rdata,   vecs[i].exp_data);
      end
    end

    // Reset with responses queued: FIFO contents must be dropped at once.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      valid = (k < 2) ? 2'b01 : 2'b00; we = 2'b00; addr[0] = 6'd1; rsp_ready = 1'b0;
    end
    #3;
    check("fifo_holding", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_run");

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_init(20, "init_mid");

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_init(-1, "reinit");

    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
    check("reinit_mem_zero", 64'(nz), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_arbiter.md
# hpdcache_sram_arbiter

Two-requester arbiter and sequencer for one single-port (1RW) byte-enable SRAM macro in the HPDcache data/directory arrays. Grants at most one access per cycle, tracks the one-cycle SRAM read latency, and returns read data through a 2-entry response FIFO with valid/ready backpressure. After reset it can zero-initialise the whole array, because the SRAM macro is never initialised by hardware.

## Interface
- ADDR_SIZE, 6, SRAM address width
- DATA_SIZE, 64, SRAM data width; multiple of 8
- DEPTH, 2**ADDR_SIZE, number of words; 1 ≤ DEPTH ≤ 2**ADDR_SIZE
- MAX_STARVE, 4, consecutive cycles requester 1 may be blocked before it wins priority; ≥ 1
- INIT_ON_RESET, 1, 1: zero-fill the array after reset; 0: skip init
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-requester request valid; index 0 has the higher base priority
- req_ready_o  out  2  per-requester grant; a request transfers when valid&&ready
- req_we_i  in  2  1 = write, 0 = read
- req_addr_i  in  2×ADDR_SIZE  word address
- req_wdata_i  in  2×DATA_SIZE  write data
- req_wbe_i  in  2×DATA_SIZE/8  write byte enables
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  read response consumed
- rsp_id_o  out  1  requester index of the response
- rsp_rdata_o  out  DATA_SIZE  read data
- init_done_o  out  1  array usable; stays high until the next reset
- sram_cs_o, sram_we_o  out  1 each  macro chip select / write enable
- sram_addr_o  out  ADDR_SIZE  macro address
- sram_wdata_o  out  DATA_SIZE  macro write data
- sram_wbe_o  out  DATA_SIZE/8  macro byte enables
- sram_rdata_i  in  DATA_SIZE  macro read data, valid the cycle after a read cs

## Operation
- FSM: INIT, RUN. Reset enters INIT if INIT_ON_RESET=1, otherwise RUN.
- INIT: counter runs 0..DEPTH-1. Each cycle drives cs=1, we=1, addr=counter, wdata=0, wbe=all ones. req_ready_o=0. After address DEPTH-1 is written, move to RUN. init_done_o rises on the first RUN cycle.
- RUN, eligibility: requester i is eligible when valid and either it is a write, or read credit is available.
- Read credit: credit is available when inflight + occupancy − pop < 2.
  - inflight: a read was granted last cycle.
  - occupancy: number of FIFO entries.
  - pop: rsp_valid_o && rsp_ready_i.
- Priority:
  - By default requester 0 wins.
  - starve_cnt increments each cycle requester 1 is valid and not granted. It clears when requester 1 is granted or when req_valid_i[1]=0, and saturates at MAX_STARVE.
  - While starve_cnt == MAX_STARVE, requester 1 wins if it is eligible.
- Grant:
  - req_ready_o is one-hot to the winner, or zero; it is combinational from the inputs and state.
  - The SRAM outputs carry the winner's fields with cs=1.
  - With no winner, cs=0, we=0, and the other SRAM outputs are don't-care.
- Read return: the cycle after a read grant, sram_rdata_i is pushed into the FIFO tagged with the granted id. Responses come out in grant order.
- Writes produce no response.
- Simultaneous push and pop of the FIFO is allowed at any occupancy. The credit rule guarantees the FIFO never overflows.

## Timing
- Reset values:
  - req_ready_o=0, rsp_valid_o=0, sram_cs_o=0, sram_we_o=0.
  - init_done_o = !INIT_ON_RESET.
  - FIFO empty, inflight=0, starve_cnt=0, init counter=0.
- INIT starts on the first clock edge after rst_n deasserts and lasts exactly DEPTH cycles.
- Read latency: grant at cycle T, SRAM data at T+1, rsp_valid_o at T+2 at the earliest.
- Sustained throughput is one access per cycle while rsp_ready_i=1.
- A stalled response allows at most 2 outstanding reads. Writes proceed regardless of response stalls.
- rst_n asserted mid-operation, including mid-INIT: all state clears immediately and any FIFO contents are discarded. INIT restarts from address 0 after release.

## Test plan
- Init, DEPTH=64, INIT_ON_RESET=1:
  - sram_cs_o=we=1 for exactly 64 cycles, addresses 0..63, wdata=0, wbe all ones.
  - req_ready_o=0 throughout; init_done_o rises on cycle 65.
- Write then read:
  - Requester 0 writes 0xDEADBEEF_CAFEF00D to addr 5 with wbe=0x0F.
  - Requester 1 then reads addr 5.
  - The response has rsp_id_o=1 and rdata=0x00000000_CAFEF00D two cycles after the grant.
- Starvation, both valid continuously, MAX_STARVE=4:
  - Requester 0 is granted for 4 cycles, then requester 1 is granted once, and the pattern repeats.
- Backpressure:
  - rsp_ready_i=0 with requester 0 issuing back-to-back reads: exactly 2 reads are granted, then req_ready_o[0]=0.
  - Interleaved writes from requester 1 are still granted each cycle.
  - Raising rsp_ready_i drains in order and resumes read grants with no lost or duplicated data.
- Simultaneous push/pop:
  - Full FIFO with rsp_ready_i=1 and a continuous read stream: rsp_valid_o stays high and one read is granted per cycle at steady state.
- Reset mid-INIT at address 20:
  - Outputs return to reset values.
  - After release, INIT restarts at 0 and completes the full DEPTH writes.
